// File: rtl/jts16_obj_pkg.sv
// jts16_obj_pkg: draw-command field layout and ROM arbiter state encoding
package jts16_obj_pkg;
  localparam int CMDW       = 43;
  localparam int XPOS_LSB   = 34;
  localparam int XPOS_W     = 9;
  localparam int OFFSET_LSB = 18;
  localparam int OFFSET_W   = 16;
  localparam int BANK_LSB   = 14;
  localparam int BANK_W     = 4;
  localparam int PRIO_LSB   = 12;
  localparam int PRIO_W     = 2;
  localparam int PAL_LSB    = 6;
  localparam int PAL_W      = 6;
  localparam int HFLIP_LSB  = 5;
  localparam int HZOOM_LSB  = 0;
  localparam int HZOOM_W    = 5;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_G0   = 2'd1,
    ARB_G1   = 2'd2
  } arb_state_t;
  function automatic logic [CMDW-1:0] pack_cmd(
    input logic [XPOS_W-1:0] xpos, input logic [OFFSET_W-1:0] offset,
    input logic [BANK_W-1:0] bank, input logic [PRIO_W-1:0] prio,
    input logic [PAL_W-1:0] pal, input logic hflipb, input logic [HZOOM_W-1:0] hzoom);
    return {xpos, offset, bank, prio, pal, hflipb, hzoom};
  endfunction
endpackage

// File: rtl/jts16_obj_romarb.sv
// jts16_obj_romarb: round-robin object-ROM arbiter with address-settle guard
module jts16_obj_romarb
  import jts16_obj_pkg::*;
#(
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hstart,
  input  logic          e0_cs,
  input  logic [AW-1:0] e0_addr,
  input  logic          e1_cs,
  input  logic [AW-1:0] e1_addr,
  output logic          e0_ok,
  output logic          e1_ok,
  output logic          obj_cs,
  output logic [AW-1:0] obj_addr,
  input  logic          obj_ok
);
  arb_state_t    st_q, st_d, o_st;
  logic          settle_q, settle_d;
  logic [AW-1:0] addr_q, addr_d, g_addr, o_addr;
  logic          g0, g1, g_cs, o_cs, done;
  always_comb begin
    g0       = st_q == ARB_G0;
    g1       = st_q == ARB_G1;
    e0_ok    = g0 & obj_ok & ~settle_q & (e0_addr == addr_q) & e0_cs;
    e1_ok    = g1 & obj_ok & ~settle_q & (e1_addr == addr_q) & e1_cs;
    g_cs     = g0 ? e0_cs : e1_cs;
    g_addr   = g0 ? e0_addr : e1_addr;
    o_cs     = g0 ? e1_cs : e0_cs;
    o_addr   = g0 ? e1_addr : e0_addr;
    o_st     = g0 ? ARB_G1 : ARB_G0;
    done     = e0_ok | e1_ok | ~g_cs;
    st_d     = st_q;
    addr_d   = addr_q;
    settle_d = 1'b0;
    if (hstart) st_d = ARB_IDLE;
    else if (st_q == ARB_IDLE) begin
      if (e0_cs | e1_cs) begin
        st_d     = e0_cs ? ARB_G0 : ARB_G1;
        addr_d   = e0_cs ? e0_addr : e1_addr;
        settle_d = 1'b1;
      end
    end else if (done) begin
      // the other engine gets the next turn, otherwise keep serving the grantee
      if (o_cs) begin
        st_d     = o_st;
        addr_d   = o_addr;
        settle_d = 1'b1;
      end else if (g_cs) begin
        addr_d   = g_addr;
        settle_d = 1'b1;
      end else st_d = ARB_IDLE;
    end else if (g_addr != addr_q) begin
      addr_d   = g_addr;
      settle_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ARB_IDLE;
      settle_q <= 1'b0;
      addr_q   <= '0;
    end else begin
      st_q     <= st_d;
      settle_q <= settle_d;
      addr_q   <= addr_d;
    end
  end
  assign obj_cs   = st_q != ARB_IDLE;
  assign obj_addr = addr_q;
endmodule

// File: rtl/jts16_obj_dispatch.sv
// jts16_obj_dispatch: feeds scanner commands to two draw engines and shares the object ROM
module jts16_obj_dispatch
  import jts16_obj_pkg::*;
#(
  parameter int CMDW = jts16_obj_pkg::CMDW,
  parameter int AW   = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hstart,
  input  logic            sc_start,
  input  logic [CMDW-1:0] sc_cmd,
  output logic            sc_busy,
  output logic [CMDW-1:0] dr_cmd,
  output logic            dr0_start,
  output logic            dr1_start,
  input  logic            dr0_busy,
  input  logic            dr1_busy,
  input  logic            e0_cs,
  input  logic            e1_cs,
  input  logic [AW-1:0]   e0_addr,
  input  logic [AW-1:0]   e1_addr,
  output logic            e0_ok,
  output logic            e1_ok,
  output logic            obj_cs,
  output logic [AW-1:0]   obj_addr,
  input  logic            obj_ok
);
  logic            hold_q, hold_d, claim0_q, claim0_d, claim1_q, claim1_d, free0, free1;
  logic [CMDW-1:0] cmd_q, cmd_d;
  always_comb begin
    // a claim bridges the gap between a start pulse and the engine raising busy
    free0     = ~dr0_busy & ~claim0_q;
    free1     = ~dr1_busy & ~claim1_q;
    dr0_start = hold_q & free0;
    dr1_start = hold_q & free1 & ~free0;
    hold_d    = ~hstart & (hold_q ? ~(dr0_start | dr1_start) : sc_start);
    cmd_d     = (~hold_q & sc_start & ~hstart) ? sc_cmd : cmd_q;
    claim0_d  = ~hstart & (dr0_start | (claim0_q & ~dr0_busy));
    claim1_d  = ~hstart & (dr1_start | (claim1_q & ~dr1_busy));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= 1'b0;
      cmd_q    <= '0;
      claim0_q <= 1'b0;
      claim1_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      cmd_q    <= cmd_d;
      claim0_q <= claim0_d;
      claim1_q <= claim1_d;
    end
  end
  assign sc_busy = hold_q;
  assign dr_cmd  = cmd_q;
  jts16_obj_romarb #(.AW(AW)) u_romarb (
    .clk      (clk),
    .rst_n    (rst_n),
    .hstart   (hstart),
    .e0_cs    (e0_cs),
    .e0_addr  (e0_addr),
    .e1_cs    (e1_cs),
    .e1_addr  (e1_addr),
    .e0_ok    (e0_ok),
    .e1_ok    (e1_ok),
    .obj_cs   (obj_cs),
    .obj_addr (obj_addr),
    .obj_ok   (obj_ok)
  );
endmodule

// File: tb/tb_jts16_obj_dispatch.sv
// tb_jts16_obj_dispatch: scoreboard bench with directed dispatch and ROM arbitration vectors
module tb_jts16_obj_dispatch;
  import jts16_obj_pkg::*;
  typedef struct { int cyc; int eng; logic [42:0] cmd; } disp_t;
  typedef struct { int cyc; int eng; logic [19:0] addr; } rom_t;
  typedef struct { int cyc; int id; logic [31:0] val; } lvl_t;
  logic        clk = 0, rst_n = 0, hstart = 0, sc_start = 0;
  logic [42:0] sc_cmd = '0, dr_cmd;
  logic        sc_busy, dr0_start, dr1_start, dr0_busy, dr1_busy;
  logic        e0_cs, e1_cs, e0_ok, e1_ok, obj_cs, obj_ok;
  logic [19:0] e0_addr, e1_addr, obj_addr;
  logic        frc0 = 0, frc1 = 0, force_ok = 0, model_en = 0, tb_clr = 0;
  logic [2:0]  cnt0 = 0, cnt1 = 0;
  logic [19:0] e0_base = 0, e1_base = 0, prev_addr = 0;
  int          e0_n = 0, e1_n = 0, done0 = 0, done1 = 0, age = 0;
  int          cyc = 0, n_run = 0, n_fail = 0;
  disp_t       disp_q[$];
  rom_t        rom_q[$];
  lvl_t        lvl_q[$];
  disp_t       d;
  rom_t        r;
  lvl_t        l;
  logic [42:0] cmd_a, cmd_b, cmd_c, cmd_d;
  jts16_obj_dispatch dut (
    .clk(clk), .rst_n(rst_n), .hstart(hstart), .sc_start(sc_start), .sc_cmd(sc_cmd),
    .sc_busy(sc_busy), .dr_cmd(dr_cmd), .dr0_start(dr0_start), .dr1_start(dr1_start),
    .dr0_busy(dr0_busy), .dr1_busy(dr1_busy), .e0_cs(e0_cs), .e1_cs(e1_cs),
    .e0_addr(e0_addr), .e1_addr(e1_addr), .e0_ok(e0_ok), .e1_ok(e1_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_ok(obj_ok)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // engines stay busy for 4 cycles starting the cycle after their start pulse
  always @(posedge clk) begin
    cnt0 <= dr0_start ? 3'd4 : (cnt0 != 0 ? cnt0 - 3'd1 : 3'd0);
    cnt1 <= dr1_start ? 3'd4 : (cnt1 != 0 ? cnt1 - 3'd1 : 3'd0);
  end
  assign dr0_busy = frc0 | (cnt0 != 0);
  assign dr1_busy = frc1 | (cnt1 != 0);
  // each engine walks e*_n consecutive addresses, advancing after every ok
  always @(posedge clk) begin
    if (tb_clr) begin
      done0 <= 0;
      done1 <= 0;
    end else begin
      if (e0_ok) done0 <= done0 + 1;
      if (e1_ok) done1 <= done1 + 1;
    end
  end
  assign e0_cs   = done0 < e0_n;
  assign e1_cs   = done1 < e1_n;
  assign e0_addr = e0_base + 20'(done0);
  assign e1_addr = e1_base + 20'(done1);
  // SDRAM answers 3 cycles after obj_addr last changed
  always @(posedge clk) begin
    prev_addr <= obj_addr;
    age       <= (obj_addr != prev_addr) ? 1 : (age < 10 ? age + 1 : age);
  end
  assign obj_ok = force_ok | (model_en & obj_cs & (obj_addr == prev_addr) & (age >= 3));

  function automatic logic [31:0] lv(input int id);
    case (id)
      0: return {31'd0, sc_busy};
      1: return {31'd0, obj_cs};
      2: return {12'd0, obj_addr};
      3: return {31'd0, dr_cmd != 0};
      default: return {31'd0, dr0_start | dr1_start | e0_ok | e1_ok};
    endcase
  endfunction
  function automatic string nm(input int id);
    case (id)
      0: return "sc_busy";
      1: return "obj_cs";
      2: return "obj_addr";
      3: return "dr_cmd_nonzero";
      default: return "any_strobe";
    endcase
  endfunction

  task automatic chk(input int c, input int id, input logic [31:0] v);
    lvl_q.push_back('{c, id, v});
  endtask
  task automatic exp_d(input int c, input int e, input logic [42:0] cmd);
    disp_q.push_back('{c, e, cmd});
  endtask
  task automatic exp_r(input int c, input int e, input logic [19:0] a);
    rom_q.push_back('{c, e, a});
  endtask
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (dr0_start || dr1_start) begin
      n_run++;
      if (disp_q.size() == 0) begin
        n_fail++;
        $display("FAIL dispatch_unexpected cyc=%0d got dr0=%0b dr1=%0b cmd=%h, required no start", cyc, dr0_start, dr1_start, dr_cmd);
      end else begin
        d = disp_q.pop_front();
        if (d.cyc != cyc || d.eng != (dr1_start ? 1 : 0) || (dr0_start && dr1_start) || d.cmd != dr_cmd) begin
          n_fail++;
          $display("FAIL dispatch got cyc=%0d dr0=%0b dr1=%0b cmd=%h, required cyc=%0d eng=%0d cmd=%h", cyc, dr0_start, dr1_start, dr_cmd, d.cyc, d.eng, d.cmd);
        end
      end
    end else if (disp_q.size() != 0 && disp_q[0].cyc < cyc) begin
      n_run++;
      n_fail++;
      d = disp_q.pop_front();
      $display("FAIL dispatch_missing got none by cyc=%0d, required eng=%0d at cyc=%0d", cyc, d.eng, d.cyc);
    end
    if (e0_ok || e1_ok) begin
      n_run++;
      if (rom_q.size() == 0) begin
        n_fail++;
        $display("FAIL rom_ok_unexpected cyc=%0d got e0_ok=%0b e1_ok=%0b addr=%h, required none", cyc, e0_ok, e1_ok, obj_addr);
      end else begin
        r = rom_q.pop_front();
        if (r.cyc != cyc || r.eng != (e1_ok ? 1 : 0) || (e0_ok && e1_ok) || r.addr != obj_addr) begin
          n_fail++;
          $display("FAIL rom_ok got cyc=%0d e0_ok=%0b e1_ok=%0b addr=%h, required cyc=%0d eng=%0d addr=%h", cyc, e0_ok, e1_ok, obj_addr, r.cyc, r.eng, r.addr);
        end
      end
    end else if (rom_q.size() != 0 && rom_q[0].cyc < cyc) begin
      n_run++;
      n_fail++;
      r = rom_q.pop_front();
      $display("FAIL rom_ok_missing got none by cyc=%0d, required eng=%0d addr=%h at cyc=%0d", cyc, r.eng, r.addr, r.cyc);
    end
    while (lvl_q.size() != 0 && lvl_q[0].cyc <= cyc) begin
      l = lvl_q.pop_front();
      n_run++;
      if (l.cyc != cyc || lv(l.id) != l.val) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got %h, required %h at cyc=%0d", nm(l.id), cyc, lv(l.id), l.val, l.cyc);
      end
    end
  end

  initial begin
    int b;
    cmd_a = pack_cmd(9'h020, 16'h1234, 4'h5, 2'd1, 6'h2a, 1'b1, 5'h10);
    cmd_b = pack_cmd(9'h040, 16'hbeef, 4'ha, 2'd3, 6'h11, 1'b0, 5'h08);
    cmd_c = pack_cmd(9'h1ff, 16'h0f0f, 4'h1, 2'd0, 6'h3f, 1'b1, 5'h1f);
    cmd_d = pack_cmd(9'h0aa, 16'h5555, 4'h7, 2'd2, 6'h05, 1'b0, 5'h01);
    for (int i = 0; i < 5; i++) chk(1, i, 0);
    goto(3);
    rst_n = 1;
    // back-to-back dispatch alternates engines
    b = 10;
    for (int c = 9; c <= 15; c++) chk(b + c, 0, (c == 11 || c == 13) ? 1 : 0);
    exp_d(b + 11, 0, cmd_a);
    exp_d(b + 13, 1, cmd_b);
    goto(b + 10); sc_start = 1; sc_cmd = cmd_a;
    goto(b + 11); sc_start = 0;
    goto(b + 12); sc_start = 1; sc_cmd = cmd_b;
    goto(b + 13); sc_start = 0;
    // both engines busy until engine 1 frees up
    b = 40;
    chk(b + 6, 0, 1); chk(b + 19, 0, 1); chk(b + 20, 0, 1); chk(b + 21, 0, 0);
    exp_d(b + 20, 1, cmd_c);
    goto(b + 1); frc0 = 1; frc1 = 1;
    goto(b + 5); sc_start = 1; sc_cmd = cmd_c;
    goto(b + 6); sc_start = 0;
    goto(b + 20); frc1 = 0;
    goto(b + 22); frc0 = 0;
    // continuous requests from both engines alternate 0,1,0,1
    b = 80;
    chk(b + 1, 2, 20'h100); chk(b + 5, 2, 20'h200); chk(b + 13, 2, 20'h201); chk(b + 18, 1, 0);
    exp_r(b + 4, 0, 20'h100); exp_r(b + 8, 1, 20'h200);
    exp_r(b + 12, 0, 20'h101); exp_r(b + 16, 1, 20'h201);
    goto(b - 2); tb_clr = 1; e0_n = 0; e1_n = 0;
    goto(b - 1); tb_clr = 0; model_en = 1; e0_base = 20'h100; e1_base = 20'h200;
    goto(b); e0_n = 2; e1_n = 2;
    // obj_ok stuck high must not leak through settle cycles
    b = 110;
    chk(b + 1, 2, 20'h300); chk(b + 3, 2, 20'h400); chk(b + 3, 1, 1); chk(b + 6, 1, 0);
    exp_r(b + 2, 0, 20'h300); exp_r(b + 4, 1, 20'h400);
    goto(b - 2); tb_clr = 1; e0_n = 0; e1_n = 0;
    goto(b - 1); tb_clr = 0; model_en = 0; force_ok = 1; e0_base = 20'h300; e1_base = 20'h400;
    goto(b); e0_n = 1; e1_n = 1;
    goto(b + 7); force_ok = 0;
    // flush during a grant, then asynchronous reset mid-grant
    b = 140;
    chk(b + 4, 1, 1); chk(b + 5, 0, 0); chk(b + 5, 1, 0); chk(b + 6, 1, 1); chk(b + 6, 2, 20'h0ab);
    for (int i = 0; i < 5; i++) chk(b + 8, i, 0);
    chk(b + 13, 1, 1); chk(b + 13, 2, 20'h555);
    exp_r(b + 16, 1, 20'h555);
    goto(b - 2); tb_clr = 1; e0_n = 0; e1_n = 0;
    goto(b - 1); tb_clr = 0; e0_base = 20'h0ab;
    goto(b); e0_n = 100;
    goto(b + 4); hstart = 1; sc_start = 1; sc_cmd = cmd_d;
    goto(b + 5); hstart = 0; sc_start = 0;
    goto(b + 8); #1 rst_n = 0;
    goto(b + 9); tb_clr = 1; e0_n = 0;
    goto(b + 10); tb_clr = 0; rst_n = 1;
    goto(b + 12); model_en = 1; e1_base = 20'h555; e1_n = 1;
    goto(b + 30);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
